// File: rtl/rom_download_sequencer.sv
// rom_download_sequencer: paces a byte stream onto the ROM download bus with sequential addresses, idle gaps and status.
module rom_download_sequencer #(
  parameter int AW       = 17,
  parameter int ROM_SIZE = 131072,
  parameter int GAP_CYC  = 2
) (
  input  logic          MCLK,
  input  logic          RESET_N,
  input  logic          START,
  input  logic          ABORT,
  input  logic [7:0]    DIN,
  input  logic          DIN_VLD,
  output logic          DIN_RDY,
  output logic          ROMCL,
  output logic [AW-1:0] ROMAD,
  output logic [7:0]    ROMDT,
  output logic          ROMEN,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output logic [7:0]    CSUM
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STROBE, S_GAP, S_DONE} state_t;
  localparam logic [AW-1:0] LAST   = AW'(ROM_SIZE - 1);
  localparam logic [7:0]    GAP_LD = 8'(GAP_CYC > 0 ? GAP_CYC - 1 : 0);
  state_t     state;
  logic [7:0] gap_cnt;
  assign ROMCL   = MCLK;
  assign DIN_RDY = state == S_LOAD;
  // download sequencer: start, accept byte, strobe, gap, advance address
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= S_IDLE;
      ROMAD   <= '0;
      ROMDT   <= '0;
      ROMEN   <= 1'b0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      CSUM    <= '0;
      gap_cnt <= '0;
    end else if (ABORT && (state == S_LOAD || state == S_STROBE || state == S_GAP)) begin
      state <= S_IDLE;
      ROMEN <= 1'b0;
      BUSY  <= 1'b0;
      ERR   <= 1'b1;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (START) begin
          ROMAD <= '0;
          CSUM  <= '0;
          DONE  <= 1'b0;
          ERR   <= 1'b0;
          BUSY  <= 1'b1;
          state <= S_LOAD;
        end
        S_LOAD: if (DIN_VLD) begin
          ROMDT <= DIN;
          ROMEN <= 1'b1;
          state <= S_STROBE;
        end
        S_STROBE: begin
          ROMEN <= 1'b0;
          CSUM  <= CSUM ^ ROMDT;
          if (ROMAD == LAST) begin
            BUSY  <= 1'b0;
            DONE  <= 1'b1;
            state <= S_DONE;
          end else if (GAP_CYC == 0) begin
            ROMAD <= ROMAD + AW'(1);
            state <= S_LOAD;
          end else begin
            gap_cnt <= GAP_LD;
            state   <= S_GAP;
          end
        end
        S_GAP: if (gap_cnt == 8'd0) begin
          ROMAD <= ROMAD + AW'(1);
          state <= S_LOAD;
        end else begin
          gap_cnt <= gap_cnt - 8'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rom_download_sequencer.sv
// tb_rom_download_sequencer: randomized and directed checks against a transaction-timing reference model.
module tb_rom_download_sequencer;
  localparam int AW = 2, RS = 4, GAP = 2;
  logic MCLK = 0, RESET_N = 0, START = 0, ABORT = 0, DIN_VLD = 0;
  logic [7:0] DIN = 0;
  logic DIN_RDY, ROMCL, ROMEN, BUSY, DONE, ERR;
  logic [7:0] ROMDT, CSUM;
  logic [AW-1:0] ROMAD;
  int vecs = 0, errs = 0;
  bit m_busy, m_done, m_err, m_en;
  int m_addr, m_wait;
  logic [7:0] m_dt, m_csum;
  always #5 MCLK = ~MCLK;
  rom_download_sequencer #(.AW(AW), .ROM_SIZE(RS), .GAP_CYC(GAP)) dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .START(START), .ABORT(ABORT), .DIN(DIN),
    .DIN_VLD(DIN_VLD), .DIN_RDY(DIN_RDY), .ROMCL(ROMCL), .ROMAD(ROMAD), .ROMDT(ROMDT),
    .ROMEN(ROMEN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .CSUM(CSUM)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void m_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_en = 0;
    m_addr = 0; m_wait = 0; m_dt = 0; m_csum = 0;
  endfunction
  // one clock edge of the download: a byte is taken when ready, written the next cycle, then GAP idle cycles
  function automatic void m_edge(input bit st, input bit ab, input bit vl, input logic [7:0] d);
    if (m_busy && ab) begin
      m_busy = 0; m_err = 1; m_en = 0; m_wait = 0;
    end else if (!m_busy && st) begin
      m_addr = 0; m_csum = 0; m_done = 0; m_err = 0; m_busy = 1; m_wait = 0; m_en = 0;
    end else if (m_busy) begin
      if (m_en) begin
        m_en = 0;
        m_csum ^= m_dt;
        if (m_addr == RS - 1) begin
          m_busy = 0; m_done = 1;
        end else if (GAP == 0) m_addr++;
        else m_wait = GAP;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_addr++;
      end else if (vl) begin
        m_en = 1; m_dt = d;
      end
    end
  endfunction
  task automatic check_all();
    chk("rdy", DIN_RDY, m_busy && !m_en && m_wait == 0);
    chk("romen", ROMEN, m_en);
    chk("romad", ROMAD, m_addr);
    chk("romdt", ROMDT, m_dt);
    chk("busy", BUSY, m_busy);
    chk("done", DONE, m_done);
    chk("err", ERR, m_err);
    chk("csum", CSUM, m_csum);
  endtask
  task automatic cyc(input bit st, input bit ab, input bit vl, input logic [7:0] d);
    START = st; ABORT = ab; DIN_VLD = vl; DIN = d;
    m_edge(st, ab, vl, d);
    @(posedge MCLK);
    @(negedge MCLK);
    check_all();
  endtask
  initial begin
    logic [7:0] b [4];
    int k;
    bit hit;
    b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h44; b[3] = 8'h88;
    m_reset();
    repeat (2) @(negedge MCLK);
    check_all();
    RESET_N = 1;
    cyc(0, 1, 1, 8'h5A);
    // fixed pattern, valid held high
    cyc(1, 0, 0, 0);
    k = 0;
    for (int i = 0; i < 40 && !m_done; i++) begin
      cyc(0, 0, 1, k < 4 ? b[k] : 8'h00);
      if (m_en) k++;
    end
    chk("csum_pattern", CSUM, 8'hFF);
    chk("done_pattern", DONE, 1);
    chk("busy_pattern", BUSY, 0);
    repeat (3) cyc(0, 0, 1, 8'h77);
    // stalled source
    cyc(1, 0, 0, 0);
    repeat (10) cyc(0, 0, 0, 8'($urandom));
    for (int i = 0; i < 40 && !m_done; i++) cyc(0, 0, 1, 8'($urandom));
    chk("done_stall", DONE, 1);
    // abort during strobe at address 1
    cyc(1, 0, 0, 0);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_en && m_addr == 1) begin hit = 1; break; end
      cyc(0, 0, 1, 8'($urandom));
    end
    chk("abort_reach", hit, 1);
    cyc(0, 1, 1, 8'($urandom));
    chk("abort_romen", ROMEN, 0);
    chk("abort_err", ERR, 1);
    chk("abort_romad", ROMAD, 1);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("restart_err", ERR, 0);
    chk("restart_romad", ROMAD, 0);
    // start pulses while busy
    for (int i = 0; i < 60 && !m_done; i++) cyc(i % 3 == 0, 0, 1, 8'($urandom));
    chk("done_startbusy", DONE, 1);
    // async reset during gap
    cyc(1, 0, 0, 0);
    hit = 0;
    for (int i = 0; i < 40; i++) begin
      if (m_wait > 0) begin hit = 1; break; end
      cyc(0, 0, 1, 8'($urandom));
    end
    chk("gap_reach", hit, 1);
    #2 RESET_N = 0;
    #1;
    chk("rst_romen", ROMEN, 0);
    chk("rst_romad", ROMAD, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_rdy", DIN_RDY, 0);
    m_reset();
    @(negedge MCLK);
    RESET_N = 1;
    check_all();
    repeat (3) cyc(0, 0, 1, 8'($urandom));
    // random traffic
    repeat (3000) cyc($urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0,
                      $urandom_range(0, 2) != 0, 8'($urandom));
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/rom_download_sequencer.md
Name: rom_download_sequencer

Overview:
- Transmitter end of the ROM download bus (ROMCL/ROMAD/ROMDT/ROMEN) consumed by the Gyruss core and its main, sub, video and sound ROM loaders.
- Accepts a byte stream from the host/HPS side over a valid/ready handshake.
- Emits one ROM write strobe per byte at sequential addresses, with a programmable idle gap between writes.
- Reports busy, done, abort/error status and a running XOR checksum.

Parameters:
- AW, 17, ROMAD width in bits.
- ROM_SIZE, 131072, number of bytes in one complete download. Legal range 1..2^AW.
- GAP_CYC, 2, idle cycles inserted after each strobe before the next byte is accepted. Legal range 0..255.

Ports:
- MCLK  in  1  system clock; all state changes on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  one-cycle pulse; begins a download. Honoured only in IDLE or DONE.
- ABORT  in  1  level; cancels a download in progress.
- DIN  in  8  stream byte.
- DIN_VLD  in  1  DIN is valid.
- DIN_RDY  out  1  sequencer accepts DIN this cycle.
- ROMCL  out  1  ROM write clock; wired directly to MCLK.
- ROMAD  out  AW  ROM write address.
- ROMDT  out  8  ROM write data.
- ROMEN  out  1  ROM write enable; one-cycle pulse per byte.
- BUSY  out  1  download in progress.
- DONE  out  1  last download completed with all ROM_SIZE bytes.
- ERR  out  1  last download was aborted.
- CSUM  out  8  XOR of all bytes written in the current/last download.

Behaviour:
- Reset (async assert, sync release): state IDLE. ROMAD=0, ROMDT=0, ROMEN=0, BUSY=0, DONE=0, ERR=0, CSUM=0, gap counter=0.
- All outputs except ROMCL and DIN_RDY are registered.
- DIN_RDY = (state==LOAD), decoded from the state register; no combinational path from DIN_VLD.
- States: IDLE, LOAD, STROBE, GAP, DONE.
- IDLE/DONE + START:
  - ROMAD<=0, CSUM<=0, DONE<=0, ERR<=0, BUSY<=1.
  - Next state LOAD.
- LOAD:
  - Handshake on an edge where DIN_VLD=1 (DIN_RDY=1 is implied by LOAD): ROMDT<=DIN, ROMEN<=1, next state STROBE.
  - Without DIN_VLD: hold indefinitely, with no timeout.
- STROBE (exactly one cycle, ROMEN=1, ROMAD and ROMDT stable):
  - ROMEN<=0, CSUM<=CSUM^ROMDT.
  - If ROMAD==ROM_SIZE-1: BUSY<=0, DONE<=1, next state DONE. ROMAD holds the last address.
  - Else if GAP_CYC==0: ROMAD<=ROMAD+1, next state LOAD.
  - Else: gap counter<=GAP_CYC-1, next state GAP.
- GAP:
  - DIN_RDY=0, ROMEN=0.
  - Counter decrements each cycle; on the edge where it equals 0, ROMAD<=ROMAD+1 and next state LOAD.
  - GAP therefore lasts exactly GAP_CYC cycles.
- Latency and throughput:
  - Byte accepted at edge t: ROMEN high during cycle t+1, address equals the byte index.
  - Peak throughput is one byte per 2+GAP_CYC cycles.
- ROMAD arithmetic is AW bits wide; ROMAD never wraps because completion is detected at ROM_SIZE-1.
- ABORT (priority over all other transitions) in LOAD/STROBE/GAP:
  - Next state IDLE, ROMEN<=0, BUSY<=0, ERR<=1.
  - ROMAD and CSUM hold their values for diagnostics.
  - A strobe pending in STROBE is truncated: ROMEN drops on the next edge.
- ABORT in IDLE/DONE: ignored.
- START during LOAD/STROBE/GAP: ignored.
- START and ABORT in the same cycle in IDLE/DONE: START wins.
- DONE state: DIN_RDY=0. Bytes offered in DONE are not consumed. DONE stays high until the next START.
- Asynchronous reset mid-download: outputs return to reset values immediately, including ROMEN=0.

Test Plan:
- ROM_SIZE=4, GAP_CYC=2, bytes 0x11,0x22,0x44,0x88 with DIN_VLD held high -> four ROMEN pulses at ROMAD 0,1,2,3 with matching ROMDT, 4 cycles apart; DONE=1, BUSY=0, CSUM=0xFF.
- GAP_CYC=0, ROM_SIZE=3, continuous valid -> DIN_RDY high every other cycle; ROMEN pulses 2 cycles apart; DONE after the 3rd strobe.
- Stalled source: DIN_VLD low for 10 cycles in LOAD -> ROMEN stays 0, ROMAD unchanged, DIN_RDY stays 1; resume -> next write at the correct address.
- ABORT asserted during the STROBE of byte 1 (ROMAD=1) -> ROMEN low on the next edge; ERR=1, BUSY=0, ROMAD=1; a following START clears ERR and restarts at ROMAD=0.
- RESET_N pulsed low mid-GAP -> ROMEN=0, ROMAD=0, BUSY=0 asynchronously; DIN_RDY=0 until the next START.
- START pulse while BUSY -> ignored; address sequence and CSUM unaffected.
